// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port, single clock.
// Registered read with write-first bypass; array contents survive reset.
module sdp_ram #(
  parameter  int WIDTH = 64,
  parameter  int SIZE  = 1024,
  localparam int ABITS = $clog2(SIZE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wren,
  input  logic [ABITS-1:0] wraddr,
  input  logic [WIDTH-1:0] wrdata,
  input  logic             rden,
  input  logic [ABITS-1:0] rdaddr,
  output logic [WIDTH-1:0] rddata
);

  localparam logic [ABITS:0] SIZE_W = SIZE[ABITS:0];

  logic [WIDTH-1:0] mem [SIZE];

  logic             wr_in_range;
  logic             rd_in_range;
  logic             wr_ok;
  logic             rd_hit;
  logic [WIDTH-1:0] rd_next;

  assign wr_in_range = ({1'b0, wraddr} < SIZE_W);
  assign rd_in_range = ({1'b0, rdaddr} < SIZE_W);
  assign wr_ok       = rst_n && wren && wr_in_range;
  assign rd_hit      = wr_ok && (wraddr == rdaddr);

  // Array kept free of reset so it maps onto block RAM; reset only gates the write.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wraddr] <= wrdata;
    end
  end

  // Out-of-range reads return zero; same-address collisions forward the new data.
  always_comb begin
    rd_next = '0;
    if (rd_in_range) begin
      if (rd_hit) begin
        rd_next = wrdata;
      end else begin
        rd_next = mem[rdaddr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rddata <= '0;
    end else if (rden) begin
      rddata <= rd_next;
    end
  end

endmodule

// File: tb/tb_sdp_ram.sv
// Directed bench for sdp_ram: a default 64x1024 instance and a
// non-power-of-two 8x1000 instance for the out-of-range behaviour.
module tb_sdp_ram;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        wren;
  logic [9:0]  wraddr;
  logic [63:0] wrdata;
  logic        rden;
  logic [9:0]  rdaddr;
  logic [63:0] rddata;

  logic        n_wren;
  logic [9:0]  n_wraddr;
  logic [7:0]  n_wrdata;
  logic        n_rden;
  logic [9:0]  n_rdaddr;
  logic [7:0]  n_rddata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sdp_ram dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .wren   (wren),
    .wraddr (wraddr),
    .wrdata (wrdata),
    .rden   (rden),
    .rdaddr (rdaddr),
    .rddata (rddata)
  );

  sdp_ram #(.WIDTH(8), .SIZE(1000)) dut_np (
    .clk    (clk),
    .rst_n  (rst_n),
    .wren   (n_wren),
    .wraddr (n_wraddr),
    .wrdata (n_wrdata),
    .rden   (n_rden),
    .rdaddr (n_rdaddr),
    .rddata (n_rddata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    wren     = 1'b1;
    wraddr   = 10'd5;
    wrdata   = 64'h77;
    rden     = 1'b1;
    rdaddr   = 10'd5;
    n_wren   = 1'b0;
    n_wraddr = '0;
    n_wrdata = '0;
    n_rden   = 1'b0;
    n_rdaddr = '0;

    // reset held 3 cycles with both enables active
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_rddata", rddata, 64'h0);
      chk("reset_np_rddata", {56'h0, n_rddata}, 64'h0);
    end
    rst_n = 1'b1;
    wren  = 1'b0;
    tick();
    total++;
    assert (rddata !== 64'h77) else begin
      bad++;
      $error("FAIL reset_write_suppressed: observed=%h must differ from %h", rddata, 64'h77);
    end

    // basic fill 0..14 then read back with 1-cycle latency
    rden = 1'b0;
    for (int i = 0; i < 15; i++) begin
      wren   = 1'b1;
      wraddr = 10'(i);
      wrdata = 64'(8'h11 + i);
      tick();
    end
    wren = 1'b0;
    for (int i = 0; i < 15; i++) begin
      rden   = 1'b1;
      rdaddr = 10'(i);
      tick();
      chk($sformatf("basic_read_%0d", i), rddata, 64'(8'h11 + i));
    end

    // hold while rden low, even with a write to the held address
    rdaddr = 10'd3;
    tick();
    chk("hold_setup", rddata, 64'h14);
    rden   = 1'b0;
    wren   = 1'b1;
    wraddr = 10'd3;
    wrdata = 64'hAA;
    rdaddr = 10'd0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_rddata", rddata, 64'h14);
    end
    wren = 1'b0;

    // write-first collision
    wren   = 1'b1;
    rden   = 1'b1;
    wraddr = 10'd7;
    rdaddr = 10'd7;
    wrdata = 64'hDEADBEEF;
    tick();
    chk("collision_bypass", rddata, 64'hDEADBEEF);
    wren = 1'b0;
    tick();
    chk("collision_stored", rddata, 64'hDEADBEEF);

    // simultaneous write/read on different addresses
    wren   = 1'b1;
    wraddr = 10'd8;
    wrdata = 64'h99;
    rdaddr = 10'd9;
    tick();
    chk("diff_addr_old", rddata, 64'h1A);
    wren   = 1'b0;
    rdaddr = 10'd8;
    tick();
    chk("diff_addr_new", rddata, 64'h99);

    // top and bottom addresses
    rden   = 1'b0;
    wren   = 1'b1;
    wraddr = 10'd1023;
    wrdata = 64'h5A;
    tick();
    wraddr = 10'd0;
    wrdata = 64'hA5;
    tick();
    wren   = 1'b0;
    rden   = 1'b1;
    rdaddr = 10'd1023;
    tick();
    chk("boundary_top", rddata, 64'h5A);
    rdaddr = 10'd0;
    tick();
    chk("boundary_zero", rddata, 64'hA5);

    // mid-operation reset keeps array contents
    rden = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wren   = 1'b1;
      wraddr = 10'(i);
      wrdata = 64'(8'h30 + i);
      tick();
    end
    wren   = 1'b0;
    rden   = 1'b1;
    rdaddr = 10'd2;
    tick();
    chk("midreset_pre", rddata, 64'h32);
    rst_n  = 1'b0;
    wren   = 1'b1;
    wraddr = 10'd1;
    wrdata = 64'hFF;
    tick();
    chk("midreset_rddata", rddata, 64'h0);
    rst_n = 1'b1;
    wren  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rdaddr = 10'(i);
      tick();
      chk($sformatf("midreset_keep_%0d", i), rddata, 64'(8'h30 + i));
    end

    // non-power-of-two instance: last valid word and out-of-range accesses
    n_wren   = 1'b1;
    n_wraddr = 10'd999;
    n_wrdata = 8'h3C;
    tick();
    n_wraddr = 10'd0;
    n_wrdata = 8'h11;
    tick();
    n_wraddr = 10'd1000;
    n_wrdata = 8'h77;
    tick();
    n_wraddr = 10'd1010;
    n_wrdata = 8'h88;
    tick();
    n_wren   = 1'b0;
    n_rden   = 1'b1;
    n_rdaddr = 10'd999;
    tick();
    chk("np_last_valid", {56'h0, n_rddata}, 64'h3C);
    n_rdaddr = 10'd1010;
    tick();
    chk("np_oob_1010", {56'h0, n_rddata}, 64'h0);
    n_rdaddr = 10'd0;
    tick();
    chk("np_addr0_intact", {56'h0, n_rddata}, 64'h11);
    n_rdaddr = 10'd1000;
    tick();
    chk("np_oob_1000", {56'h0, n_rddata}, 64'h0);
    n_rdaddr = 10'd999;
    tick();
    chk("np_last_intact", {56'h0, n_rddata}, 64'h3C);
    n_wren   = 1'b1;
    n_wraddr = 10'd1010;
    n_wrdata = 8'h55;
    n_rdaddr = 10'd1010;
    tick();
    chk("np_oob_collision", {56'h0, n_rddata}, 64'h0);
    n_wren = 1'b0;
    n_rden = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
